icache_refill_ctrl: RTL and testbench
=====================================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter BLOCK_WIDTH, default 2, log2 of words per instruction block.
REQ-002 Parameter BLOCK_SIZE, default 1 << BLOCK_WIDTH, words per block (block = 4*BLOCK_SIZE bytes).
REQ-003 clk_in  input  1  single clock, all state on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  high = run, low = pause.
REQ-006 flush_in  input  1  abort any refill in progress (branch redirect).
REQ-007 icache_query_en  input  1  one-cycle refill request from the instruction cache.
REQ-008 icache_query_addr  input  32  block byte address; bits [BLOCK_WIDTH+1:0] ignored.
REQ-009 icache_data_en  output  1  one-cycle pulse, block valid.
REQ-010 icache_data  output  32*BLOCK_SIZE  fetched block, byte k at bits [8k+7:8k].
REQ-011 mem_din  input  8  RAM read data; mem_din in cycle t = RAM[mem_a in cycle t-1].
REQ-012 mem_dout  output  8  RAM write data, constant 0.
REQ-013 mem_a  output  32  RAM byte address.
REQ-014 mem_wr  output  1  RAM write enable, constant 0 (read-only port).

Function
REQ-015 States SHALL be IDLE and FETCH; FSM, issue pointer and handshakes advance only at edges where rdy_in=1.
REQ-016 In IDLE with icache_query_en=1 and flush_in=0, SHALL latch base={addr[31:BLOCK_WIDTH+2], 0s}, clear byte-valid mask, issue pointer=0, go FETCH.
REQ-017 In FETCH, mem_a SHALL equal base+issue pointer (combinational); pointer increments per running edge until 4*BLOCK_SIZE-1, then holds.
REQ-018 Outside FETCH, mem_a SHALL be 0.
REQ-019 Capture path SHALL run every edge regardless of rdy_in: register previous-cycle mem_a and a valid flag; if valid, write mem_din into byte (prev_a-base) and set its mask bit.
REQ-020 Repeated capture of the same byte (pause holding mem_a) SHALL be idempotent.
REQ-021 When mask is all ones at a running edge in FETCH, SHALL set icache_data_en=1 for exactly one cycle, load icache_data, return to IDLE.
REQ-022 Latency with rdy_in=1 throughout, BLOCK_WIDTH=2: query sampled at edge E0, mem_a=base+k in cycle k+1, icache_data_en high in cycle after edge E17.
REQ-023 icache_data SHALL hold its value until the next icache_data_en pulse.
REQ-024 icache_query_en while in FETCH SHALL be ignored.
REQ-025 flush_in=1 at a running edge SHALL force IDLE, clear mask and capture-valid, suppress icache_data_en; flush wins over simultaneous query or completion.
REQ-026 Address arithmetic SHALL be 32-bit modulo (base near 0xFFFFFFF0 wraps, no error).

Reset
REQ-027 While rst_in=0: state IDLE, mask 0, capture-valid 0, issue pointer 0, icache_data_en 0, icache_data 0, mem_a 0, mem_wr 0, mem_dout 0.
REQ-028 Reset assertion mid-FETCH SHALL abort immediately with no pulse; first request after release is served normally.

Structure
REQ-029 Shared package SHALL hold BLOCK_WIDTH/BLOCK_SIZE defaults and the IDLE/FETCH state encoding, also used by the instruction cache.
REQ-030 Single module, no sub-modules; mask and byte assembly are plain registers.

Verification
REQ-031 RAM 0x100..0x10F = 0x00..0x0F, query 0x108 -> one pulse 17 edges later, icache_data=0x0F0E..0100, mem_a 0x100..0x10F sequential.
REQ-032 Same query, rdy_in low 3 cycles after mem_a=0x105 -> identical block, pulse delayed exactly 3 cycles.
REQ-033 flush_in at 8th FETCH cycle -> no pulse, mem_a=0 next cycle; new query 0x200 then served correctly.
REQ-034 Second query asserted mid-FETCH -> ignored, exactly one pulse for first block.
REQ-035 rst_in low mid-FETCH -> all outputs 0 at once; after release query 0x300 returns correct block.
REQ-036 Query 0xFFFFFFF4 -> mem_a 0xFFFFFFF0..0xFFFFFFFF, block assembled, single pulse.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill path: block geometry
// defaults and the refill FSM state encoding.
package icache_refill_ctrl_pkg;

  localparam int DEFAULT_BLOCK_WIDTH = 2;
  localparam int DEFAULT_BLOCK_SIZE  = 1 << DEFAULT_BLOCK_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache block refill: streams one block byte-by-byte from a
// byte-wide read-only RAM and hands the assembled block back to the cache.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH,
  parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      icache_query_en,
  input  logic [31:0]               icache_query_addr,
  output logic                      icache_data_en,
  output logic [32*BLOCK_SIZE-1:0]  icache_data,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr
);

  localparam int NBYTES = 4 * BLOCK_SIZE;
  localparam int PW     = BLOCK_WIDTH + 2;
  localparam logic [PW-1:0] PTR_LAST  = PW'(NBYTES - 1);
  localparam logic [31:0]   BASE_MASK = ~32'(NBYTES - 1);

  refill_state_e           state_reg, state_next;
  logic [31:0]             base_reg, base_next;
  logic [PW-1:0]           ptr_reg, ptr_next;
  logic [NBYTES-1:0]       mask_reg, mask_next, mask_cap;
  logic [8*NBYTES-1:0]     asm_reg, asm_next;
  logic [PW-1:0]           cap_off_reg, cap_off_next;
  logic                    cap_valid_reg, cap_valid_next;
  logic                    data_en_reg, data_en_next;
  logic [32*BLOCK_SIZE-1:0] data_reg, data_next;

  assign mem_a          = (state_reg == FETCH) ? base_reg + 32'(ptr_reg) : 32'h0;
  assign mem_dout       = 8'h00;
  assign mem_wr         = 1'b0;
  assign icache_data_en = data_en_reg;
  assign icache_data    = data_reg;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    ptr_next       = ptr_reg;
    cap_off_next   = mem_a[PW-1:0];
    cap_valid_next = (state_reg == FETCH);
    data_en_next   = 1'b0;
    data_next      = data_reg;
    mask_cap       = mask_reg;
    asm_next       = asm_reg;

    // Capture runs on every edge; base is block-aligned, so the low address
    // bits are the byte offset. Re-capturing a held address rewrites the same byte.
    if (cap_valid_reg) begin
      asm_next[{cap_off_reg, 3'b000} +: 8] = mem_din;
      mask_cap[cap_off_reg]                = 1'b1;
    end
    mask_next = mask_cap;

    if (rdy_in) begin
      case (state_reg)
        IDLE: begin
          if (flush_in) begin
            mask_next = '0;
          end else if (icache_query_en) begin
            base_next  = icache_query_addr & BASE_MASK;
            ptr_next   = '0;
            mask_next  = '0;
            state_next = FETCH;
          end
        end
        FETCH: begin
          if (flush_in) begin
            state_next     = IDLE;
            mask_next      = '0;
            cap_valid_next = 1'b0;
          end else if (&mask_cap) begin
            // Completion sees the byte landing on this very edge.
            state_next     = IDLE;
            data_en_next   = 1'b1;
            data_next      = asm_next;
            cap_valid_next = 1'b0;
          end else if (ptr_reg != PTR_LAST) begin
            ptr_next = ptr_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      base_reg      <= '0;
      ptr_reg       <= '0;
      mask_reg      <= '0;
      asm_reg       <= '0;
      cap_off_reg   <= '0;
      cap_valid_reg <= 1'b0;
      data_en_reg   <= 1'b0;
      data_reg      <= '0;
    end else begin
      base_reg      <= base_next;
      ptr_reg       <= ptr_next;
      mask_reg      <= mask_next;
      asm_reg       <= asm_next;
      cap_off_reg   <= cap_off_next;
      cap_valid_reg <= cap_valid_next;
      data_en_reg   <= data_en_next;
      data_reg      <= data_next;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized scoreboard bench for icache_refill_ctrl: expected blocks and
// their completion edges are queued at issue time and matched by a monitor.
module tb_icache_refill_ctrl;

  logic         clk_in;
  logic         rst_in;
  logic         rdy_in;
  logic         flush_in;
  logic         icache_query_en;
  logic [31:0]  icache_query_addr;
  logic         icache_data_en;
  logic [127:0] icache_data;
  logic [7:0]   mem_din;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;

  icache_refill_ctrl dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .flush_in          (flush_in),
    .icache_query_en   (icache_query_en),
    .icache_query_addr (icache_query_addr),
    .icache_data_en    (icache_data_en),
    .icache_data       (icache_data),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr)
  );

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           edge_cnt = 0;
  logic [127:0] last_data = '0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  // RAM contents: 0x100..0x10F read back as 0x00..0x0F.
  function automatic logic [7:0] ram_f(input logic [31:0] a);
    logic [7:0] hi;
    hi = a[15:8] - 8'd1;
    return a[7:0] ^ 8'(hi * 8'h37) ^ a[23:16] ^ a[31:24];
  endfunction

  always @(posedge clk_in) mem_din <= ram_f(mem_a);

  function automatic logic [127:0] block_f(input logic [31:0] base);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = ram_f(base + 32'(i));
    return d;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest queued block at its due edge.
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (icache_data_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 128'(icache_data_en), 128'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("block_data", icache_data, e.data);
          chk("pulse_edge", 128'(edge_cnt), 128'(e.due));
          last_data = e.data;
        end
      end else begin
        chk("data_hold", icache_data, last_data);
      end
      chk("mem_wr_dout", {mem_wr, mem_dout}, 128'd0);
    end else begin
      last_data = '0;
    end
  end

  // abort_at>0 aborts by flush (or reset if abort_rst) at edge E0+abort_at.
  task automatic run_txn(input logic [31:0] addr, input int pause_pct, input int pause_from,
                         input int abort_at, input bit abort_rst);
    logic [31:0] base;
    bit          pat[64];
    int          x, k, r, e0;
    exp_t        e;
    base = addr & 32'hFFFF_FFF0;
    for (int j = 0; j < 64; j++)
      pat[j] = (j >= 40) ? 1'b1 : ($urandom_range(99) >= pause_pct);
    if (pause_from > 0)
      for (int j = pause_from; j < pause_from + 3; j++) pat[j] = 1'b0;
    if (abort_at > 0) pat[abort_at] = 1'b1;
    r = 0;
    x = 0;
    for (int j = 1; j < 64; j++) begin
      if (pat[j]) r++;
      if (r == 15) begin x = j; break; end
    end
    // Last byte lands two edges after its address is issued; done at next running edge.
    k = x + 2;
    while (!pat[k]) k++;

    @(negedge clk_in);
    icache_query_en   = 1'b1;
    icache_query_addr = addr;
    rdy_in            = 1'b1;
    flush_in          = 1'b0;
    e0 = edge_cnt + 1;
    if (abort_at <= 0) begin
      e.data = block_f(base);
      e.due  = e0 + k;
      sb.push_back(e);
    end
    $display("txn addr=%h abort=%0d rst=%0d due_offset=%0d", addr, abort_at, abort_rst, k);

    r = 0;
    for (int j = 1; j <= k; j++) begin
      @(negedge clk_in);
      chk("mem_a_fetch", 128'(mem_a), 128'(base + 32'((r > 15) ? 15 : r)));
      if (abort_at > 0 && j == abort_at) begin
        if (abort_rst) begin
          icache_query_en = 1'b0;
          #2 rst_in = 1'b0;
          #1;
          chk("rst_outputs", {icache_data_en, icache_data}, 129'd0);
          chk("rst_mem", {mem_a, mem_wr, mem_dout}, 128'd0);
          @(negedge clk_in);
          #2 rst_in = 1'b1;
        end else begin
          flush_in        = 1'b1;
          rdy_in          = 1'b1;
          icache_query_en = 1'($urandom_range(1));
          @(negedge clk_in);
          flush_in        = 1'b0;
          icache_query_en = 1'b0;
          chk("mem_a_after_flush", 128'(mem_a), 128'd0);
        end
        return;
      end
      rdy_in            = pat[j];
      icache_query_en   = 1'($urandom_range(1));
      icache_query_addr = $urandom;
      if (pat[j]) r++;
    end
    @(negedge clk_in);
    icache_query_en = 1'b0;
    rdy_in          = 1'b1;
    chk("mem_a_idle", 128'(mem_a), 128'd0);
  endtask

  initial begin
    rst_in            = 1'b0;
    rdy_in            = 1'b1;
    flush_in          = 1'b0;
    icache_query_en   = 1'b0;
    icache_query_addr = '0;
    repeat (3) @(negedge clk_in);
    chk("reset_data", {icache_data_en, icache_data}, 129'd0);
    chk("reset_mem", {mem_a, mem_wr, mem_dout}, 128'd0);
    #2 rst_in = 1'b1;
    @(negedge clk_in);

    run_txn(32'h0000_0108, 0, 0, 0, 1'b0);
    run_txn(32'h0000_0108, 0, 6, 0, 1'b0);
    run_txn(32'h0000_0108, 0, 0, 8, 1'b0);
    run_txn(32'h0000_0200, 0, 0, 0, 1'b0);
    run_txn(32'h0000_0108, 0, 0, 5, 1'b1);
    run_txn(32'h0000_0300, 0, 0, 0, 1'b0);
    run_txn(32'hFFFF_FFF4, 0, 0, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int sel;
      sel = $urandom_range(7);
      run_txn($urandom, $urandom_range(40), 0,
              (sel < 2) ? $urandom_range(17, 1) : 0, sel == 1);
      repeat ($urandom_range(3)) begin
        @(negedge clk_in);
        flush_in = 1'($urandom_range(1));
        rdy_in   = 1'($urandom_range(1));
      end
      @(negedge clk_in);
      flush_in = 1'b0;
      rdy_in   = 1'b1;
    end

    repeat (5) @(negedge clk_in);
    chk("missing_pulse", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
